// File: rtl/uart_stream_tx.sv
// uart_stream_tx: FIFO-buffered UART transmitter that starts frames only while the Bluetooth link is up
module uart_stream_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic [15:0]                 baud_div,
    input  logic [1:0]                  parity_mode,
    input  logic                        bt_state,
    input  logic                        send_break,
    output logic                        fpga_txd,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow,
    output logic                        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_WIDTH);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
    state_t                state;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] shreg;
    logic [15:0]           timer, div_l, div_eff;
    logic [BW-1:0]         bit_idx;
    logic                  par_en, par_bit, stop_cnt;
    logic                  push, pop, bit_end;
    assign full    = count == (AW+1)'(FIFO_DEPTH);
    assign empty   = count == '0;
    assign busy    = state != IDLE;
    assign push    = wr_en && !full;
    assign pop     = state == IDLE && !send_break && !empty && bt_state;
    assign div_eff = baud_div == 16'd0 ? 16'd1 : baud_div;
    assign bit_end = timer == 16'd0;
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push != pop) count <= push ? count + (AW+1)'(1) : count - (AW+1)'(1);
            if (wr_en && full) overflow <= 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
    // fpga_txd is updated together with each state change so the line is glitch-free
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            fpga_txd <= 1'b1;
            timer    <= '0;
            shreg    <= '0;
            bit_idx  <= '0;
            div_l    <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            stop_cnt <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (send_break) begin
                        state    <= BREAK;
                        fpga_txd <= 1'b0;
                    end else if (pop) begin
                        state    <= START;
                        fpga_txd <= 1'b0;
                        timer    <= div_eff - 16'd1;
                        div_l    <= div_eff;
                        shreg    <= mem[rd_ptr];
                        par_en   <= ^parity_mode;
                        par_bit  <= (^mem[rd_ptr]) ^ parity_mode[1];
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        fpga_txd <= shreg[0];
                        shreg    <= shreg >> 1;
                        bit_idx  <= '0;
                        timer    <= div_l - 16'd1;
                    end else timer <= timer - 16'd1;
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= div_l - 16'd1;
                        if (bit_idx == BW'(DATA_WIDTH-1)) begin
                            state    <= par_en ? PARITY : STOP;
                            fpga_txd <= par_en ? par_bit : 1'b1;
                            stop_cnt <= 1'b0;
                        end else begin
                            fpga_txd <= shreg[0];
                            shreg    <= shreg >> 1;
                            bit_idx  <= bit_idx + BW'(1);
                        end
                    end else timer <= timer - 16'd1;
                end
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        fpga_txd <= 1'b1;
                        stop_cnt <= 1'b0;
                        timer    <= div_l - 16'd1;
                    end else timer <= timer - 16'd1;
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop_cnt == 1'(STOP_BITS-1)) state <= IDLE;
                        else begin
                            stop_cnt <= 1'b1;
                            timer    <= div_l - 16'd1;
                        end
                    end else timer <= timer - 16'd1;
                end
                BREAK: begin
                    if (!send_break) begin
                        state    <= IDLE;
                        fpga_txd <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    fpga_txd <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_stream_tx.sv
// tb_uart_stream_tx: directed self-checking bench for uart_stream_tx
module tb_uart_stream_tx;
    logic        clock = 1'b0, reset = 1'b1, wr_en = 1'b0, bt_state = 1'b0, send_break = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic [15:0] baud_div = 16'd4;
    logic [1:0]  parity_mode = 2'b00;
    logic        fpga_txd, full, empty, overflow, busy;
    logic [4:0]  count;
    int          checks = 0, errors = 0, n;
    always #5 clock = ~clock;
    uart_stream_tx dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .baud_div(baud_div),
        .parity_mode(parity_mode), .bt_state(bt_state), .send_break(send_break), .fpga_txd(fpga_txd),
        .full(full), .empty(empty), .count(count), .overflow(overflow), .busy(busy)
    );
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic push(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask
    function automatic logic fbit(input logic [7:0] d, input logic [1:0] pm, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[3'(b-1)];
        if (b == 9 && (pm == 2'b01 || pm == 2'b10)) return pm == 2'b01 ? ^d : ~^d;
        return 1'b1;
    endfunction
    task automatic expect_bits(input logic [15:0] bits, input int nb, input int div, input string tag);
        for (int k = 0; k < nb * div; k++) begin
            chk({tag, " txd"}, 32'(fpga_txd), 32'(bits[4'(k / div)]));
            if (k == nb * div - 1) chk({tag, " busy last"}, 32'(busy), 1);
            tick();
        end
        chk({tag, " idle after"}, 32'(busy), 0);
        chk({tag, " txd idle"}, 32'(fpga_txd), 1);
    endtask
    task automatic expect_frame(input logic [7:0] d, input logic [1:0] pm, input int div, input string tag);
        logic [15:0] bits = '0;
        int nb = (pm == 2'b01 || pm == 2'b10) ? 11 : 10;
        for (int b = 0; b < nb; b++) bits[4'(b)] = fbit(d, pm, b);
        expect_bits(bits, nb, div, tag);
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        tick();
        tick();
        chk("rst txd", 32'(fpga_txd), 1);
        chk("rst busy", 32'(busy), 0);
        chk("rst count", 32'(count), 0);
        chk("rst empty", 32'(empty), 1);
        chk("rst full", 32'(full), 0);
        chk("rst overflow", 32'(overflow), 0);
        reset = 1'b0;
        bt_state = 1'b1;
        // A5, no parity, div 4
        push(8'hA5);
        chk("t1 count", 32'(count), 1);
        chk("t1 no start yet", 32'(busy), 0);
        tick();
        chk("t1 popped", 32'(count), 0);
        expect_bits(16'b11_0100_1010, 10, 4, "t1 A5");
        // 07 even parity
        parity_mode = 2'b01;
        push(8'h07);
        tick();
        expect_bits(16'b110_0000_1110, 11, 4, "t2 07 even");
        // 07 odd parity; mid-frame setting changes must not affect this frame
        parity_mode = 2'b10;
        push(8'h07);
        tick();
        parity_mode = 2'b00;
        baud_div = 16'd2;
        expect_bits(16'b100_0000_1110, 11, 4, "t3 07 odd latched");
        baud_div = 16'd4;
        // fill with link down, overflow on 17th write
        bt_state = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h10 + 8'(i);
            tick();
            if (i == 15) begin
                chk("t4 full at 16", 32'(full), 1);
                chk("t4 count 16", 32'(count), 16);
                chk("t4 no overflow yet", 32'(overflow), 0);
            end
        end
        wr_en = 1'b0;
        chk("t4 overflow", 32'(overflow), 1);
        chk("t4 count still 16", 32'(count), 16);
        chk("t4 full", 32'(full), 1);
        for (int i = 0; i < 3; i++) begin
            chk("t4 link down idle", 32'(busy), 0);
            tick();
        end
        bt_state = 1'b1;
        tick();
        chk("t4 count after pop", 32'(count), 15);
        for (int i = 0; i < 16; i++) begin
            expect_frame(8'h10 + 8'(i), 2'b00, 4, "t4 drain");
            if (i < 15) tick();
        end
        chk("t4 empty", 32'(empty), 1);
        chk("t4 overflow sticky", 32'(overflow), 1);
        // link drops mid-frame with 3 words queued
        wr_en = 1'b1;
        wr_data = 8'h3C;
        tick();
        chk("t5 count w1", 32'(count), 1);
        wr_data = 8'hC3;
        tick();
        chk("t5 push+pop count", 32'(count), 1);
        chk("t5 started", 32'(fpga_txd), 0);
        wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        chk("t5 count 2", 32'(count), 2);
        for (int i = 0; i < 4; i++) tick();
        bt_state = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("t5 frame completes", n, 35);
        for (int i = 0; i < 20; i++) begin
            chk("t5 held txd", 32'(fpga_txd), 1);
            chk("t5 held count", 32'(count), 2);
            tick();
        end
        bt_state = 1'b1;
        tick();
        chk("t5 resume count", 32'(count), 1);
        expect_frame(8'hC3, 2'b00, 4, "t5 w2");
        tick();
        expect_frame(8'h5A, 2'b00, 4, "t5 w3");
        // break raised during frame for 20 clocks
        push(8'h81);
        tick();
        for (int k = 0; k < 56; k++) begin
            chk("t6 txd", 32'(fpga_txd), 32'(k < 40 ? fbit(8'h81, 2'b00, k / 4) : (k == 40 || k > 50) ? 1'b1 : 1'b0));
            if (k == 30) send_break = 1'b1;
            if (k == 50) send_break = 1'b0;
            tick();
        end
        chk("t6 busy after break", 32'(busy), 0);
        // reset mid-frame with 5 words queued
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1;
            wr_data = 8'hE0 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("t7 count 5", 32'(count), 5);
        chk("t7 busy", 32'(busy), 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t7 txd", 32'(fpga_txd), 1);
        chk("t7 count", 32'(count), 0);
        chk("t7 busy", 32'(busy), 0);
        chk("t7 overflow", 32'(overflow), 0);
        chk("t7 empty", 32'(empty), 1);
        push(8'h3A);
        chk("t8 write accepted", 32'(count), 1);
        chk("t8 no start yet", 32'(busy), 0);
        tick();
        expect_frame(8'h3A, 2'b00, 4, "t8 after reset");
        // break in IDLE wins over pending pop
        send_break = 1'b1;
        push(8'h42);
        chk("t9 break busy", 32'(busy), 1);
        chk("t9 break txd", 32'(fpga_txd), 0);
        chk("t9 word kept", 32'(count), 1);
        tick();
        tick();
        chk("t9 break held", 32'(fpga_txd), 0);
        send_break = 1'b0;
        tick();
        chk("t9 back idle", 32'(busy), 0);
        chk("t9 txd high", 32'(fpga_txd), 1);
        chk("t9 count kept", 32'(count), 1);
        tick();
        chk("t9 popped", 32'(count), 0);
        expect_frame(8'h42, 2'b00, 4, "t9 frame");
        // baud_div 0 acts as 1
        baud_div = 16'd0;
        push(8'h55);
        tick();
        expect_frame(8'h55, 2'b00, 1, "t10 div0");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
